bp_fe_bp_update_fifo: RTL and testbench

Front-end branch-resolution tracker that sits directly upstream of the branch predictor's write port. It records the BHT index and the prediction made for every predicted branch at fetch time. When the backend later resolves those branches in program order, it pops the matching record and drives a registered update (valid, index, correct) into the predictor. It also keeps a saturating misprediction counter for performance monitoring.

---
 rtl/bp_fe_bp_update_fifo.sv | 152 +++++++++++++++
 tb/tb_bp_fe_bp_update_fifo.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bp_fe_bp_update_fifo.sv
// bp_fe_bp_update_fifo
//
// Tracks every predicted branch from fetch until the backend resolves it.
// Each record holds the BHT index and the predicted direction. Branches
// resolve in program order, so each resolve pops the oldest record. One
// cycle later the block drives a registered update into the predictor's
// write port. A saturating 16-bit misprediction counter supports
// performance monitoring.
//
// Parameters
//   bht_idx_width_p  BHT index width; must match the predictor's. There is
//                    no usable default, so every instance must override it.
//   entries_p        in-flight branch capacity (power of two, >= 2)
//
// Ports
//   clk_i             clock; all state changes on the rising edge
//   reset_i           synchronous, active-high reset
//   fetch_v_i         a predicted branch is issued this cycle
//   fetch_idx_i       BHT index used for that prediction
//   fetch_pred_i      prediction made (1 = taken)
//   fetch_ready_o     a slot is free; a push happens on fetch_v_i & fetch_ready_o
//   res_v_i           the oldest outstanding branch resolved this cycle
//   res_taken_i       actual direction of that branch
//   flush_i           discard all outstanding records
//   w_v_o             predictor update valid (single-cycle pulse)
//   idx_w_o           index to update
//   correct_o         1 when the stored prediction matched the actual direction
//   err_o             single-cycle pulse: a resolve arrived with nothing outstanding
//   mispredict_cnt_o  saturating count of resolved mispredictions

module bp_fe_bp_update_fifo #(
  parameter              bht_idx_width_p = "inv",
  parameter int unsigned entries_p       = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic                       fetch_v_i,
  input  logic [bht_idx_width_p-1:0] fetch_idx_i,
  input  logic                       fetch_pred_i,
  output logic                       fetch_ready_o,

  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  input  logic                       flush_i,

  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic                       err_o,
  output logic [15:0]                mispredict_cnt_o
);

  localparam int unsigned ptr_w = $clog2(entries_p);
  localparam int unsigned cnt_w = ptr_w + 1;

  localparam logic [cnt_w-1:0] full_count = cnt_w'(entries_p);

  // Each record is {index, prediction}; the prediction sits in bit 0.
  logic [bht_idx_width_p:0] mem [entries_p];

  logic [ptr_w-1:0] wptr_r;
  logic [ptr_w-1:0] rptr_r;
  logic [cnt_w-1:0] count_r;

  logic                       push;
  logic                       pop;
  logic                       empty_res;
  logic                       empty;
  logic [bht_idx_width_p:0]   head;
  logic [bht_idx_width_p-1:0] head_idx;
  logic                       head_pred;
  logic                       head_correct;
  logic [cnt_w-1:0]           count_next;

  // Readiness depends only on the registered count. A pop in the same cycle
  // does not make room for a push while the FIFO is full. This keeps the
  // ready path free of any dependence on the resolve inputs.
  assign fetch_ready_o = ~reset_i & (count_r != full_count);

  assign empty = (count_r == '0);

  // A flush cancels any fetch or resolve presented in the same cycle.
  assign push      = fetch_v_i & fetch_ready_o & ~flush_i;
  assign pop       = res_v_i & ~empty & ~flush_i;
  assign empty_res = res_v_i &  empty & ~flush_i;

  assign head         = mem[rptr_r];
  assign head_idx     = head[bht_idx_width_p:1];
  assign head_pred    = head[0];
  assign head_correct = (head_pred == res_taken_i);

  always_comb begin
    count_next = count_r;
    unique case ({push, pop})
      2'b10:   count_next = count_r + cnt_w'(1);
      2'b01:   count_next = count_r - cnt_w'(1);
      default: count_next = count_r;
    endcase
  end

  // The storage array has no reset. Its contents do not matter after a
  // reset or flush because count and the pointers define which entries are
  // live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr_r] <= {fetch_idx_i, fetch_pred_i};
    end
  end

  // Pointer and occupancy state. Both pointers wrap naturally at entries_p,
  // which is a power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i | flush_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) wptr_r <= wptr_r + ptr_w'(1);
      if (pop)  rptr_r <= rptr_r + ptr_w'(1);
      count_r <= count_next;
    end
  end

  // Registered update port. The index and correct fields hold their last
  // value between updates, and only w_v_o qualifies them.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_v_o     <= 1'b0;
      idx_w_o   <= '0;
      correct_o <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      w_v_o <= pop;
      err_o <= empty_res;
      if (pop) begin
        idx_w_o   <= head_idx;
        correct_o <= head_correct;
      end
    end
  end

  // The misprediction counter survives a flush; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mispredict_cnt_o <= '0;
    end else if (pop && !head_correct && (mispredict_cnt_o != '1)) begin
      mispredict_cnt_o <= mispredict_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_bp_fe_bp_update_fifo.sv
module tb_bp_fe_bp_update_fifo;

  localparam int W = 6;
  localparam int ENTRIES = 8;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         fetch_v_i;
  logic [W-1:0] fetch_idx_i;
  logic         fetch_pred_i;
  logic         fetch_ready_o;
  logic         res_v_i;
  logic         res_taken_i;
  logic         flush_i;
  logic         w_v_o;
  logic [W-1:0] idx_w_o;
  logic         correct_o;
  logic         err_o;
  logic [15:0]  mispredict_cnt_o;

  always #5 clk_i = ~clk_i;

  bp_fe_bp_update_fifo #(.bht_idx_width_p(W), .entries_p(ENTRIES)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .fetch_v_i(fetch_v_i), .fetch_idx_i(fetch_idx_i), .fetch_pred_i(fetch_pred_i),
    .fetch_ready_o(fetch_ready_o),
    .res_v_i(res_v_i), .res_taken_i(res_taken_i), .flush_i(flush_i),
    .w_v_o(w_v_o), .idx_w_o(idx_w_o), .correct_o(correct_o), .err_o(err_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  typedef struct {
    logic [W-1:0] idx;
    logic         pred;
  } rec_t;

  // Reference model: a queue of outstanding branches and the expected
  // registered outputs.
  rec_t         q[$];
  logic         e_wv, e_err, e_cor, e_data;
  logic [W-1:0] e_idx;
  int           e_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. The task is entered shortly after a falling edge. It
  // drives the inputs, checks ready, steps the model, waits for the next
  // falling edge and then checks the registered outputs.
  task automatic cycle(input logic fv, input logic [W-1:0] fi, input logic fp,
                       input logic rv, input logic rt, input logic fl, input logic rs);
    logic exp_ready;
    rec_t r;
    reset_i = rs; fetch_v_i = fv; fetch_idx_i = fi; fetch_pred_i = fp;
    res_v_i = rv; res_taken_i = rt; flush_i = fl;
    #1;
    exp_ready = !rs && (q.size() != ENTRIES);
    chk("fetch_ready", 32'(fetch_ready_o), 32'(exp_ready));
    e_wv = 1'b0; e_err = 1'b0; e_data = 1'b0;
    if (rs) begin
      q.delete(); e_idx = '0; e_cor = 1'b0; e_cnt = 0; e_data = 1'b1;
    end else if (fl) begin
      q.delete();
    end else begin
      if (rv) begin
        if (q.size() == 0) e_err = 1'b1;
        else begin
          r = q.pop_front();
          e_wv = 1'b1; e_data = 1'b1; e_idx = r.idx; e_cor = (r.pred == rt);
          if (!e_cor && e_cnt < 65535) e_cnt++;
        end
      end
      if (fv && exp_ready) begin
        r.idx = fi; r.pred = fp;
        q.push_back(r);
      end
    end
    @(negedge clk_i);
    chk("w_v", 32'(w_v_o), 32'(e_wv));
    chk("err", 32'(err_o), 32'(e_err));
    chk("mispredict_cnt", 32'(mispredict_cnt_o), 32'(e_cnt[15:0]));
    if (e_data) begin
      chk("idx_w", 32'(idx_w_o), 32'(e_idx));
      chk("correct", 32'(correct_o), 32'(e_cor));
    end
  endtask

  task automatic push(input logic [W-1:0] fi, input logic fp);
    cycle(1'b1, fi, fp, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic rt);
    cycle(1'b0, '0, 1'b0, 1'b1, rt, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    e_cnt = 0; e_wv = 0; e_err = 0; e_cor = 0; e_idx = '0; e_data = 0;

    // Reset
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();

    // Basic: (3,1) and (5,0), both resolve taken
    push(6'd3, 1'b1);
    push(6'd5, 1'b0);
    resolve(1'b1);
    resolve(1'b1);
    chk("basic_cnt_is_1", 32'(mispredict_cnt_o), 32'd1);

    // Fill to capacity, ignored 9th fetch, then a pop reopens a slot
    for (int i = 0; i < ENTRIES; i++) push(W'(i + 10), i[0]);
    push(6'd63, 1'b1);
    resolve(1'b0);
    idle();

    // Drain, then wrap the pointers with 20 push/pop pairs
    for (int i = 0; i < ENTRIES - 1; i++) resolve(1'b1);
    push(6'd20, 1'b0);
    for (int i = 0; i < 20; i++)
      cycle(1'b1, W'(i + 21), i[1], 1'b1, i[0], 1'b0, 1'b0);
    resolve(1'b0);

    // Empty resolve, with and without a same-cycle push
    resolve(1'b1);
    cycle(1'b1, 6'd42, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    resolve(1'b1);

    // Flush with a concurrent fetch and resolve
    for (int i = 0; i < 4; i++) push(W'(i + 1), 1'b1);
    cycle(1'b1, 6'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    resolve(1'b0);

    // Reset while 3 entries are pending and a pop is in flight
    for (int i = 0; i < 4; i++) push(W'(i + 30), 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle();
    resolve(1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));

    // Saturation of the misprediction counter
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(6'd7, 1'b1);
    for (int i = 0; i < 65540; i++)
      cycle(1'b1, W'(i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("saturated", 32'(mispredict_cnt_o), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
